// File: rtl/snn_output_decoder_pkg.sv
// Shared definitions for the SNN output decoder.
//   state_e         : decoder FSM states (IDLE, ACCUM, SCAN, HOLD)
//   DEF_OUTPUT_SIZE : default number of output-layer classes
//   DEF_COUNT_WIDTH : default width of each per-class spike counter
//   DEF_IDX_WIDTH   : default width of the class index
package snn_output_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SCAN  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam int DEF_OUTPUT_SIZE = 10;
  localparam int DEF_COUNT_WIDTH = 8;
  localparam int DEF_IDX_WIDTH   = 4;

endpackage

// File: rtl/snn_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, zeroes the count
//   clr   : synchronous clear, zeroes the count (wins over inc)
//   inc   : add one, holding at all-ones instead of wrapping
//   count : current count
module snn_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/snn_output_decoder.sv
// SNN output decoder: counts output-layer spikes per class over an inference
// window, then scans the counters one per cycle to find the winning class.
//   clk, rst        : clock (rising edge), synchronous active-high reset
//   start           : pulse opening a new window (IDLE, or restart in ACCUM)
//   spike_valid     : qualifies output_spikes for one time step
//   output_spikes   : per-class spike vector from the compute core
//   compute_done    : window end, sampled in ACCUM
//   class_id        : winning class index (lowest index wins ties)
//   max_count       : spike count of the winning class
//   tie             : another class reached the same non-zero count
//   no_spike        : every counter was zero
//   class_valid     : result valid (HOLD state)
//   class_ready     : consumer accepts the result
//   busy            : high outside IDLE
//   dbg_state       : current FSM state, for observation only
//
// Result handshake: class_valid rises when the scan completes and stays high,
// with class_id/max_count/tie/no_spike frozen, until a cycle in which
// class_valid && class_ready; that cycle is the transfer and class_valid drops
// on the following edge. class_ready while class_valid is low does nothing.
module snn_output_decoder
  import snn_output_decoder_pkg::*;
#(
  parameter int OUTPUT_SIZE = DEF_OUTPUT_SIZE,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int IDX_WIDTH   = DEF_IDX_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   spike_valid,
  input  logic [OUTPUT_SIZE-1:0] output_spikes,
  input  logic                   compute_done,
  output logic [IDX_WIDTH-1:0]   class_id,
  output logic [COUNT_WIDTH-1:0] max_count,
  output logic                   tie,
  output logic                   no_spike,
  output logic                   class_valid,
  input  logic                   class_ready,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(OUTPUT_SIZE - 1);

  state_e                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   scan_idx_q, scan_idx_d;
  // Running argmax while scanning; kept apart from the published result so
  // the previous result stays visible until the new scan finishes.
  logic [IDX_WIDTH-1:0]   run_idx_q, run_idx_d;
  logic [COUNT_WIDTH-1:0] run_max_q, run_max_d;
  logic                   run_tie_q, run_tie_d;
  logic [IDX_WIDTH-1:0]   class_id_q, class_id_d;
  logic [COUNT_WIDTH-1:0] max_count_q, max_count_d;
  logic                   tie_q, tie_d;
  logic                   no_spike_q, no_spike_d;

  logic                   cnt_clr;
  logic                   cnt_inc_en;
  logic [COUNT_WIDTH-1:0] counts [OUTPUT_SIZE];
  logic [COUNT_WIDTH-1:0] cur_cnt;

  // A start in ACCUM is a restart: it clears and suppresses that cycle's spikes.
  assign cnt_clr    = start && ((state_q == ST_IDLE) || (state_q == ST_ACCUM));
  assign cnt_inc_en = (state_q == ST_ACCUM) && !start && spike_valid;

  for (genvar g = 0; g < OUTPUT_SIZE; g++) begin : g_cnt
    snn_sat_counter #(
      .WIDTH (COUNT_WIDTH)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .inc   (cnt_inc_en && output_spikes[g]),
      .count (counts[g])
    );
  end

  assign cur_cnt = counts[scan_idx_q];

  always_comb begin
    state_d     = state_q;
    scan_idx_d  = scan_idx_q;
    run_idx_d   = run_idx_q;
    run_max_d   = run_max_q;
    run_tie_d   = run_tie_q;
    class_id_d  = class_id_q;
    max_count_d = max_count_q;
    tie_d       = tie_q;
    no_spike_d  = no_spike_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (!start && compute_done) begin
          state_d    = ST_SCAN;
          scan_idx_d = '0;
        end
      end
      ST_SCAN: begin
        // Index 0 seeds the running max; later indices replace it only when
        // strictly greater, so the lowest index wins ties. Equal zero counts
        // are not a tie.
        if (scan_idx_q == '0) begin
          run_idx_d = '0;
          run_max_d = cur_cnt;
          run_tie_d = 1'b0;
        end else if (cur_cnt > run_max_q) begin
          run_idx_d = scan_idx_q;
          run_max_d = cur_cnt;
          run_tie_d = 1'b0;
        end else if ((cur_cnt == run_max_q) && (cur_cnt != '0)) begin
          run_tie_d = 1'b1;
        end

        if (scan_idx_q == LAST_IDX) begin
          state_d     = ST_HOLD;
          class_id_d  = run_idx_d;
          max_count_d = run_max_d;
          tie_d       = run_tie_d;
          no_spike_d  = (run_max_d == '0);
        end else begin
          scan_idx_d = scan_idx_q + IDX_WIDTH'(1);
        end
      end
      ST_HOLD: begin
        if (class_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      scan_idx_q  <= '0;
      run_idx_q   <= '0;
      run_max_q   <= '0;
      run_tie_q   <= 1'b0;
      class_id_q  <= '0;
      max_count_q <= '0;
      tie_q       <= 1'b0;
      no_spike_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_idx_q  <= scan_idx_d;
      run_idx_q   <= run_idx_d;
      run_max_q   <= run_max_d;
      run_tie_q   <= run_tie_d;
      class_id_q  <= class_id_d;
      max_count_q <= max_count_d;
      tie_q       <= tie_d;
      no_spike_q  <= no_spike_d;
    end
  end

  assign class_id    = class_id_q;
  assign max_count   = max_count_q;
  assign tie         = tie_q;
  assign no_spike    = no_spike_q;
  assign class_valid = (state_q == ST_HOLD);
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_snn_output_decoder.sv
// Directed testbench for snn_output_decoder with default parameters.
module tb_snn_output_decoder;

  localparam int N  = 10;
  localparam int CW = 8;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          spike_valid;
  logic [N-1:0]  output_spikes;
  logic          compute_done;
  logic [IW-1:0] class_id;
  logic [CW-1:0] max_count;
  logic          tie;
  logic          no_spike;
  logic          class_valid;
  logic          class_ready;
  logic          busy;
  logic [1:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  snn_output_decoder #(
    .OUTPUT_SIZE (N),
    .COUNT_WIDTH (CW),
    .IDX_WIDTH   (IW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .spike_valid   (spike_valid),
    .output_spikes (output_spikes),
    .compute_done  (compute_done),
    .class_id      (class_id),
    .max_count     (max_count),
    .tie           (tie),
    .no_spike      (no_spike),
    .class_valid   (class_valid),
    .class_ready   (class_ready),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] onehot(input int k);
    logic [N-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic spike_step(input logic [N-1:0] vec);
    spike_valid   = 1'b1;
    output_spikes = vec;
    tick();
    spike_valid   = 1'b0;
    output_spikes = '0;
  endtask

  // Samples compute_done (optionally with a final spike vector), waits for
  // class_valid and checks the done-to-valid latency in cycles.
  task automatic end_window(input string tag, input logic last_valid, input logic [N-1:0] last_vec);
    int lat;
    compute_done  = 1'b1;
    spike_valid   = last_valid;
    output_spikes = last_vec;
    tick();
    compute_done  = 1'b0;
    spike_valid   = 1'b0;
    output_spikes = '0;
    lat = 1;
    while (!class_valid && lat < 40) begin
      // Spikes during SCAN must be ignored.
      spike_valid   = 1'b1;
      output_spikes = '1;
      tick();
      lat++;
    end
    spike_valid   = 1'b0;
    output_spikes = '0;
    check({tag, "_latency"}, lat, N + 1);
  endtask

  task automatic accept();
    class_ready = 1'b1;
    tick();
    class_ready = 1'b0;
  endtask

  task automatic check_result(input string tag, input int id, input int mc, input logic t, input logic ns);
    check({tag, "_valid"}, class_valid, 1);
    check({tag, "_class_id"}, class_id, id);
    check({tag, "_max_count"}, max_count, mc);
    check({tag, "_tie"}, tie, t);
    check({tag, "_no_spike"}, no_spike, ns);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [IW-1:0] id_snap;
    logic [CW-1:0] mc_snap;

    rst = 1'b1; start = 1'b0; spike_valid = 1'b0; output_spikes = '0;
    compute_done = 1'b0; class_ready = 1'b0;
    tick(); tick();
    // start and ready asserted during reset must be dominated by it
    start = 1'b1; class_ready = 1'b1;
    tick();
    start = 1'b0; class_ready = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_valid", class_valid, 0);
    check("rst_class_id", class_id, 0);
    check("rst_max_count", max_count, 0);
    check("rst_tie", tie, 0);
    check("rst_no_spike", no_spike, 0);
    rst = 1'b0;
    // ready without valid: no effect
    class_ready = 1'b1; tick(); class_ready = 1'b0;
    check("idle_ready_busy", busy, 0);

    // Window 1: class 3 every step, class 7 every other step; step 99
    // coincides with compute_done and must still be counted.
    spike_step(onehot(5));           // IDLE: ignored
    pulse_start();
    check("start_busy", busy, 1);
    for (int i = 0; i < 99; i++)
      spike_step(onehot(3) | ((i % 2 == 0) ? onehot(7) : '0));
    end_window("w1", 1'b1, onehot(3));
    check_result("w1", 3, 100, 1'b0, 1'b0);

    // Hold 20 cycles without ready, with a start pulse in the middle.
    id_snap = class_id; mc_snap = max_count;
    for (int c = 0; c < 20; c++) begin
      start = (c == 5);
      tick();
      check("hold_valid", class_valid, 1);
      check("hold_class_id", class_id, id_snap);
      check("hold_max_count", max_count, mc_snap);
    end
    start = 1'b0;
    accept();
    check("accept_valid", class_valid, 0);
    check("accept_busy", busy, 0);
    tick();
    check("no_queued_start", busy, 0);
    check("idle_keep_class_id", class_id, 3);
    check("idle_keep_max_count", max_count, 100);

    // Window 2: classes 2 and 5 at 40 each -> lowest index, tie.
    pulse_start();
    for (int i = 0; i < 40; i++) spike_step(onehot(2) | onehot(5));
    end_window("w2", 1'b0, '0);
    check_result("w2", 2, 40, 1'b1, 1'b0);
    accept();

    // Window 3: 0 and 1 tie at 5, then class 2 at 6 clears the tie.
    pulse_start();
    for (int i = 0; i < 5; i++) spike_step(onehot(0) | onehot(1) | onehot(2));
    spike_step(onehot(2));
    end_window("w3", 1'b0, '0);
    check_result("w3", 2, 6, 1'b0, 1'b0);
    accept();

    // Window 4: 100 empty steps.
    pulse_start();
    for (int i = 0; i < 100; i++) spike_step('0);
    end_window("w4", 1'b0, '0);
    check_result("w4", 0, 0, 1'b0, 1'b1);
    accept();

    // Window 5: class 1 for 300 steps saturates at 255.
    pulse_start();
    for (int i = 0; i < 300; i++) spike_step(onehot(1));
    end_window("w5", 1'b0, '0);
    check_result("w5", 1, 255, 1'b0, 1'b0);
    accept();

    // Restart in ACCUM: class 6 x20, start (with spikes and done), class 8 x3.
    pulse_start();
    for (int i = 0; i < 20; i++) spike_step(onehot(6));
    start = 1'b1; compute_done = 1'b1; spike_valid = 1'b1; output_spikes = onehot(6);
    tick();
    start = 1'b0; compute_done = 1'b0; spike_valid = 1'b0; output_spikes = '0;
    check("restart_still_accum", dbg_state, 1);
    for (int i = 0; i < 3; i++) spike_step(onehot(8));
    end_window("rs", 1'b0, '0);
    check_result("rs", 8, 3, 1'b0, 1'b0);
    accept();

    // Reset at step 50, then a fresh window of class 4 x10.
    pulse_start();
    for (int i = 0; i < 50; i++) spike_step(onehot(4));
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_max_count", max_count, 0);
    pulse_start();
    for (int i = 0; i < 10; i++) spike_step(onehot(4));
    end_window("r2", 1'b0, '0);
    check_result("r2", 4, 10, 1'b0, 1'b0);

    // Reset in HOLD discards the result.
    rst = 1'b1; tick(); rst = 1'b0;
    check("hold_rst_valid", class_valid, 0);
    check("hold_rst_class_id", class_id, 0);
    tick();
    check("hold_rst_stays_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
